// File: rtl/udp_tx_path.sv
// UDP transmit path: collects one application packet into a word RAM
// (store-and-forward), then emits a UDP header followed by the payload
// as an AXI-Stream byte stream.
module udp_tx_path #(
  parameter int DATA_W    = 64,
  parameter int MAX_BYTES = 2048,
  parameter int IP_TTL    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           din_data,
  input  logic [$clog2(DATA_W/8):0]   din_bytes,
  input  logic                        din_valid,
  input  logic                        din_last,
  output logic                        din_ready,
  output logic                        tx_udp_hdr_valid,
  input  logic                        tx_udp_hdr_ready,
  output logic [5:0]                  tx_udp_ip_dscp,
  output logic [1:0]                  tx_udp_ip_ecn,
  output logic [7:0]                  tx_udp_ip_ttl,
  output logic [31:0]                 tx_udp_ip_source_ip,
  output logic [31:0]                 tx_udp_ip_dest_ip,
  output logic [15:0]                 tx_udp_source_port,
  output logic [15:0]                 tx_udp_dest_port,
  output logic [15:0]                 tx_udp_length,
  output logic [15:0]                 tx_udp_checksum,
  output logic [7:0]                  tx_udp_payload_axis_tdata,
  output logic                        tx_udp_payload_axis_tvalid,
  input  logic                        tx_udp_payload_axis_tready,
  output logic                        tx_udp_payload_axis_tlast,
  output logic                        tx_udp_payload_axis_tuser,
  input  logic [31:0]                 local_ip,
  input  logic [31:0]                 dest_ip,
  input  logic [15:0]                 local_port,
  input  logic [15:0]                 dest_port
);

  localparam int BPW   = DATA_W / 8;
  localparam int DEPTH = MAX_BYTES / BPW;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(MAX_BYTES) + 2;
  localparam int BIW   = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {COLLECT, DROP, HDR, PAYLOAD} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] rd_data, cur_word;
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_addr;
  logic [CW-1:0]     byte_cnt, out_cnt, add_bytes, total;
  logic [BIW-1:0]    bidx;
  logic              cur_valid, accept, ovf, byte_fire, word_end, advance;
  logic [15:0]       len_q, src_port_q, dst_port_q;
  logic [31:0]       src_ip_q, dst_ip_q;

  assign tx_udp_ip_dscp             = '0;
  assign tx_udp_ip_ecn              = '0;
  assign tx_udp_ip_ttl              = 8'(IP_TTL);
  assign tx_udp_checksum            = '0;
  assign tx_udp_payload_axis_tuser  = 1'b0;
  assign tx_udp_ip_source_ip        = src_ip_q;
  assign tx_udp_ip_dest_ip          = dst_ip_q;
  assign tx_udp_source_port         = src_port_q;
  assign tx_udp_dest_port           = dst_port_q;
  assign tx_udp_length              = len_q;

  assign tx_udp_payload_axis_tvalid = (state == PAYLOAD) && cur_valid;
  assign tx_udp_payload_axis_tlast  = tx_udp_payload_axis_tvalid &&
                                      (out_cnt == byte_cnt - CW'(1));
  assign tx_udp_payload_axis_tdata  = tx_udp_payload_axis_tvalid ? cur_word[7:0] : '0;

  assign accept    = din_valid && din_ready;
  assign byte_fire = tx_udp_payload_axis_tvalid && tx_udp_payload_axis_tready;
  assign word_end  = (bidx == BIW'(BPW - 1));
  // The read address runs one word ahead so rd_data always holds the word
  // following cur_word; this lets word boundaries pass without a bubble.
  assign advance   = (state == PAYLOAD) &&
                     (!cur_valid || (byte_fire && word_end && !tx_udp_payload_axis_tlast));
  assign rd_addr   = advance ? rd_ptr + AW'(1) : rd_ptr;

  // Byte count contributed by the incoming word and overflow detection
  always_comb begin
    add_bytes = CW'(BPW);
    if (din_last && (din_bytes != '0)) add_bytes = CW'(din_bytes);
    total = byte_cnt + add_bytes;
    ovf   = (total > CW'(MAX_BYTES));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next       = state;
    din_ready        = 1'b0;
    tx_udp_hdr_valid = 1'b0;
    case (state)
      COLLECT: begin
        din_ready = 1'b1;
        if (din_valid) begin
          if (ovf && !din_last)       state_next = DROP;
          else if (!ovf && din_last)  state_next = HDR;
        end
      end
      DROP: begin
        din_ready = 1'b1;
        if (din_valid && din_last) state_next = COLLECT;
      end
      HDR: begin
        tx_udp_hdr_valid = 1'b1;
        if (tx_udp_hdr_ready) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        if (byte_fire && tx_udp_payload_axis_tlast) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Packet word RAM: write on stored words, registered read
  always_ff @(posedge clk) begin
    if ((state == COLLECT) && accept && !ovf) ram[wr_ptr] <= din_data;
    rd_data <= ram[rd_addr];
  end

  // Collection counters, header latches and payload byte sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      byte_cnt   <= '0;
      out_cnt    <= '0;
      bidx       <= '0;
      cur_valid  <= 1'b0;
      cur_word   <= '0;
      len_q      <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (ovf) begin
              wr_ptr   <= '0;
              byte_cnt <= '0;
            end else begin
              wr_ptr   <= wr_ptr + AW'(1);
              byte_cnt <= total;
              if (din_last) begin
                len_q      <= 16'(total + CW'(8));
                src_ip_q   <= local_ip;
                dst_ip_q   <= dest_ip;
                src_port_q <= local_port;
                dst_port_q <= dest_port;
              end
            end
          end
        end
        DROP: begin
          if (accept && din_last) begin
            wr_ptr   <= '0;
            byte_cnt <= '0;
          end
        end
        PAYLOAD: begin
          if (!cur_valid) begin
            cur_word  <= rd_data;
            cur_valid <= 1'b1;
            rd_ptr    <= rd_ptr + AW'(1);
            bidx      <= '0;
          end else if (byte_fire) begin
            if (tx_udp_payload_axis_tlast) begin
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              byte_cnt  <= '0;
              out_cnt   <= '0;
              bidx      <= '0;
              cur_valid <= 1'b0;
            end else begin
              out_cnt <= out_cnt + CW'(1);
              if (word_end) begin
                cur_word <= rd_data;
                rd_ptr   <= rd_ptr + AW'(1);
                bidx     <= '0;
              end else begin
                cur_word <= cur_word >> 8;
                bidx     <= bidx + BIW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_path.sv
// Directed bench for udp_tx_path with hand-computed expected headers/payloads.
module tb_udp_tx_path;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] din_data = '0;
  logic [3:0]  din_bytes = '0;
  logic        din_valid = 1'b0;
  logic        din_last = 1'b0;
  logic        din_ready;
  logic        hdr_valid;
  logic        hdr_ready = 1'b1;
  logic [5:0]  dscp;
  logic [1:0]  ecn;
  logic [7:0]  ttl;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port, udp_len, udp_csum;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser;
  logic        tready = 1'b1;
  logic [31:0] cfg_local_ip = 32'hC0A8_0001;
  logic [31:0] cfg_dest_ip  = 32'hC0A8_0002;
  logic [15:0] cfg_local_port = 16'd1234;
  logic [15:0] cfg_dest_port  = 16'd5678;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  logic [7:0] got_q[$];
  logic       got_last[$];
  logic [7:0] exp_q[$];
  logic       pkt_done = 1'b0;
  int unsigned gap_cnt = 0, stall_err = 0, stall_cycles = 0, hdr_cycles = 0;
  logic       pat_en = 1'b0;
  logic [3:0] pat = 4'b1001;

  udp_tx_path #(.DATA_W(64), .MAX_BYTES(64), .IP_TTL(64)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_bytes(din_bytes), .din_valid(din_valid),
    .din_last(din_last), .din_ready(din_ready),
    .tx_udp_hdr_valid(hdr_valid), .tx_udp_hdr_ready(hdr_ready),
    .tx_udp_ip_dscp(dscp), .tx_udp_ip_ecn(ecn), .tx_udp_ip_ttl(ttl),
    .tx_udp_ip_source_ip(src_ip), .tx_udp_ip_dest_ip(dst_ip),
    .tx_udp_source_port(src_port), .tx_udp_dest_port(dst_port),
    .tx_udp_length(udp_len), .tx_udp_checksum(udp_csum),
    .tx_udp_payload_axis_tdata(tdata), .tx_udp_payload_axis_tvalid(tvalid),
    .tx_udp_payload_axis_tready(tready), .tx_udp_payload_axis_tlast(tlast),
    .tx_udp_payload_axis_tuser(tuser),
    .local_ip(cfg_local_ip), .dest_ip(cfg_dest_ip),
    .local_port(cfg_local_port), .dest_port(cfg_dest_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // tready driver: constant 1 or the repeating 1,0,0,1 pattern
  initial begin
    int unsigned k;
    k = 0;
    forever begin
      @(posedge clk); #1;
      if (pat_en) begin
        tready = pat[k];
        k = (k + 1) % 4;
      end else begin
        tready = 1'b1;
      end
    end
  end

  // Payload monitor: records handshaken bytes, gaps, stall stability, header cycles
  initial begin
    logic       in_pkt, prev_stall, prev_last;
    logic [7:0] prev_data;
    in_pkt = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pkt = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !(tvalid && tdata == prev_data && tlast == prev_last)) stall_err++;
        if (in_pkt && tready && !tvalid) gap_cnt++;
        if (hdr_valid) hdr_cycles++;
        if (tvalid && !tready) stall_cycles++;
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
        if (tvalid && tready) begin
          got_q.push_back(tdata);
          got_last.push_back(tlast);
          in_pkt = !tlast;
          if (tlast) pkt_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_rx();
    got_q.delete();
    got_last.delete();
    pkt_done = 1'b0;
    gap_cnt = 0;
    stall_err = 0;
    stall_cycles = 0;
  endtask

  // Present one word and hold it until accepted; returns at posedge+1
  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int unsigned n;
    n = 0;
    din_data = d; din_last = last; din_bytes = nb; din_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!din_ready && n < 100);
    if (!din_ready) check("din_ready_timeout", 64'(din_ready), 64'd1);
    @(posedge clk); #1;
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  // Send exp_q as a packet; a full last word is encoded as din_bytes=0
  task automatic send_bytes(input int unsigned n);
    int unsigned nw;
    logic [63:0] d;
    nw = (n + 7) / 8;
    for (int unsigned w = 0; w < nw; w++) begin
      d = {8{8'hEE}};
      for (int unsigned b = 0; b < 8; b++)
        if (w * 8 + b < n) d[b*8 +: 8] = exp_q[w*8+b];
      send_word(d, w == nw - 1, 4'((n - 8 * (nw - 1)) % 8));
    end
  endtask

  task automatic wait_hdr(input logic [15:0] len);
    int unsigned n;
    n = 0;
    do begin @(negedge clk); n++; end while (!hdr_valid && n < 50);
    check("hdr_valid", 64'(hdr_valid), 64'd1);
    check("udp_length", 64'(udp_len), 64'(len));
    check("src_ip", 64'(src_ip), 64'(cfg_local_ip));
    check("dst_ip", 64'(dst_ip), 64'(cfg_dest_ip));
    check("ports", {32'd0, src_port, dst_port}, {32'd0, cfg_local_port, cfg_dest_port});
    check("ttl_dscp_ecn_csum", {32'd0, ttl, dscp, ecn, udp_csum}, {32'd0, 8'd64, 6'd0, 2'd0, 16'd0});
    check("din_ready_in_hdr", 64'(din_ready), 64'd0);
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    do begin @(negedge clk); n++; end while (!pkt_done && n < 400);
    check("pkt_done", 64'(pkt_done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_pkt(input string tag);
    int unsigned n;
    n = exp_q.size();
    check({tag, "_count"}, 64'(got_q.size()), 64'(n));
    for (int unsigned i = 0; i < n && i < got_q.size(); i++)
      check({tag, "_byte"}, {55'd0, got_last[i], got_q[i]}, {55'd0, (i == n - 1), exp_q[i]});
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_din_ready", 64'(din_ready), 64'd1);
    check("rst_flags", {60'd0, hdr_valid, tvalid, tlast, tuser}, 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_fields", {src_ip, udp_len, dst_port}, 64'd0);
    @(posedge clk); #1;

    // Single full word, din_bytes=8
    clear_rx();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_word(64'h0807060504030201, 1'b1, 4'd8);
    wait_hdr(16'd16);
    wait_done();
    check_pkt("one_word");
    @(negedge clk);
    check("din_ready_after_pkt", 64'(din_ready), 64'd1);
    @(posedge clk); #1;

    // Two words, last with 3 bytes, no gaps
    clear_rx();
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
    send_word(64'h1817161514131211, 1'b0, 4'd0);
    send_word(64'hFFFF_FFFF_FF1B_1A19, 1'b1, 4'd3);
    wait_hdr(16'd19);
    wait_done();
    check_pkt("eleven");
    check("no_gaps", 64'(gap_cnt), 64'd0);

    // Header backpressure for 10 cycles
    clear_rx();
    hdr_ready = 1'b0;
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    send_word(64'h2827262524232221, 1'b1, 4'd5);
    wait_hdr(16'd13);
    begin
      int unsigned bad;
      bad = 0;
      for (int unsigned c = 0; c < 10; c++) begin
        @(negedge clk);
        if (!hdr_valid || udp_len != 16'd13 || src_ip != cfg_local_ip ||
            dst_port != cfg_dest_port || din_ready || tvalid) bad++;
      end
      check("hdr_hold_cycles_bad", 64'(bad), 64'd0);
    end
    @(posedge clk); #1;
    hdr_ready = 1'b1;
    wait_done();
    check_pkt("hdr_stall");

    // tready pattern 1,0,0,1 over a 16-byte packet
    clear_rx();
    pat_en = 1'b1;
    exp_q.delete();
    for (int unsigned i = 0; i < 16; i++) exp_q.push_back(8'(8'h30 + i));
    send_bytes(16);
    wait_hdr(16'd24);
    wait_done();
    pat_en = 1'b0;
    check_pkt("stall");
    check("stall_stable_err", 64'(stall_err), 64'd0);
    check("stalls_seen", 64'(stall_cycles != 0), 64'd1);
    @(posedge clk); #1;

    // Oversize packets: 9 words (overflow on last) and 10 words (DROP path)
    clear_rx();
    begin
      int unsigned h0;
      h0 = hdr_cycles;
      for (int unsigned w = 0; w < 9; w++) send_word({8{8'(w)}}, w == 8, 4'd0);
      for (int unsigned w = 0; w < 10; w++) send_word({8{8'(w + 8'h80)}}, w == 9, 4'd0);
      repeat (5) @(negedge clk);
      check("drop_no_header", 64'(hdr_cycles - h0), 64'd0);
      check("drop_no_payload", 64'(got_q.size()), 64'd0);
      check("drop_din_ready", 64'(din_ready), 64'd1);
    end
    @(posedge clk); #1;
    clear_rx();
    exp_q = '{8'hAA};
    send_word(64'h5555_5555_5555_55AA, 1'b1, 4'd1);
    wait_hdr(16'd9);
    wait_done();
    check_pkt("one_byte");

    // Exactly MAX_BYTES (64) payload
    clear_rx();
    exp_q.delete();
    for (int unsigned i = 0; i < 64; i++) exp_q.push_back(8'(i * 7 + 3));
    send_bytes(64);
    wait_hdr(16'd72);
    wait_done();
    check_pkt("max");
    check("max_no_gaps", 64'(gap_cnt), 64'd0);

    // Reset mid-payload, then a clean packet
    clear_rx();
    exp_q.delete();
    for (int unsigned i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
    send_bytes(16);
    wait_hdr(16'd24);
    begin
      int unsigned n;
      n = 0;
      while (got_q.size() < 3 && n < 50) begin @(negedge clk); n++; end
      check("pre_abort_bytes", 64'(got_q.size() >= 3), 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_din_ready", 64'(din_ready), 64'd1);
    check("abort_flags", {60'd0, hdr_valid, tvalid, tlast, tuser}, 64'd0);
    check("abort_tdata", 64'(tdata), 64'd0);
    check("abort_fields", {src_ip, udp_len, dst_port}, 64'd0);
    @(posedge clk); #1;
    clear_rx();
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    send_bytes(8);
    wait_hdr(16'd16);
    wait_done();
    check_pkt("post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
